serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Bit-serial two's-complement/unsigned subtractor. It computes DIFF = A - B one bit per clock, LSB first, using a single full-subtractor cell and a registered borrow. It is the subtract-direction counterpart of the team's adder cells. It sits beside the adder datapath wherever area matters more than latency, and uses a start/done handshake toward a controlling FSM.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
clk  input  1  rising-edge clock.
reset_n  input  1  asynchronous active-low reset.
start  input  1  request pulse; samples a and b when the block is ready.
a  input  WIDTH  minuend, sampled on the accepting start edge.
b  input  WIDTH  subtrahend, sampled on the accepting start edge.
ready  output  1  high when a start will be accepted (IDLE or DONE).
busy  output  1  high while bits are being processed (RUN).
done  output  1  one-cycle pulse when diff and borrow become valid.
diff  output  WIDTH  A - B modulo 2^WIDTH; held until the next accepted start.
borrow  output  1  final borrow-out: 1 iff A < B unsigned; held with diff.

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-low on reset_n. Assertion takes effect immediately. Deassertion is used synchronously to clk.
- Reset values: state=IDLE, ready=1, busy=0, done=0, diff=0, borrow=0. Internal shift registers, borrow flop and bit counter are all 0.
- States:
  - IDLE: ready=1. start=1 -> load a_sh<=a, b_sh<=b, bflop<=0, cnt<=0; go to RUN.
  - RUN: busy=1, ready=0. Each cycle:
    - d = a_sh[0]^b_sh[0]^bflop.
    - bout = (~a_sh[0]&b_sh[0]) | (~(a_sh[0]^b_sh[0])&bflop).
    - Shift a_sh and b_sh right by 1.
    - Shift d into the result register from the MSB side: res <= {d, res[WIDTH-1:1]}.
    - bflop <= bout, cnt <= cnt+1.
    - When cnt==WIDTH-1, this cycle's bit is the last; go to DONE.
  - DONE: done=1 for exactly this cycle. diff<=res and borrow<=bflop are registered on entry, so both are valid while done=1. ready=1.
    - start=1 -> reload the operands and go to RUN (back-to-back operation).
    - start=0 -> go to IDLE.
- Latency: accepting start edge at cycle 0 -> done=1 during cycle WIDTH+1. Throughput with back-to-back starts: one result per WIDTH+1 cycles.
- start while busy=1 is ignored. The operation in flight is not disturbed, and the ignored request is not queued.
- a and b are don't-care except on the accepting edge. Changing them during RUN has no effect.
- diff and borrow change only on entry to DONE. They are stable through IDLE and RUN of the following operation.
- Counter width: clog2(WIDTH)+1 bits; it must not overflow at WIDTH=32.
- Reset during RUN aborts the operation: all outputs return to their reset values and no done pulse is issued.
- Signed interpretation is left to the user: diff is correct two's-complement modulo 2^WIDTH. borrow is the unsigned borrow, not signed overflow.

Test Plan:
- WIDTH=8, a=0x35, b=0x12, one start pulse -> busy high for 8 cycles; done pulse at cycle 9 with diff=0x23, borrow=0.
- a=0x00, b=0x01 -> diff=0xFF, borrow=1. a=0xFF, b=0xFF -> diff=0x00, borrow=0. a=0x80, b=0x7F -> diff=0x01, borrow=0.
- Start held high continuously with a=0x10, b=0x20, then a=0x05, b=0x03 presented on the DONE cycle -> done pulses 9 cycles apart with diff=0xF0/borrow=1, then diff=0x02/borrow=0; ready=1 only on IDLE/DONE cycles.
- Accept a=0x40, b=0x01, then pulse start and change a/b at RUN cycles 3 and 5 -> a single done pulse with diff=0x3F, borrow=0.
- Drop reset_n asynchronously mid-RUN (cycle 4) -> outputs go to 0 and ready to 1 immediately; no done pulse; the next start with a=0x09, b=0x04 gives diff=0x05.
- Random check over 1000 pairs at WIDTH=8 and WIDTH=32 -> diff=(a-b) mod 2^WIDTH and borrow=(a<b) every time; done is exactly one cycle wide.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b one bit per clock, LSB first, through a
// single full-subtractor cell with a registered borrow. Start/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic             bflop;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bout;

  // Full-subtractor cell on the current LSBs.
  always_comb begin
    d    = a_sh[0] ^ b_sh[0] ^ bflop;
    bout = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & bflop);
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      ready  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      bflop  <= 1'b0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            bflop <= 1'b0;
            cnt   <= '0;
            state <= RUN;
            ready <= 1'b0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end
        end
        RUN: begin
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          res   <= {d, res[WIDTH-1:1]};
          bflop <= bout;
          cnt   <= cnt + 1'b1;
          // The last bit goes straight into diff so the result is valid with done.
          if (cnt == LAST) begin
            state  <= DONE;
            done   <= 1'b1;
            ready  <= 1'b1;
            busy   <= 1'b0;
            diff   <= {d, res[WIDTH-1:1]};
            borrow <= bout;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: directed handshake cases at WIDTH=8 and random
// operand pairs at WIDTH=8 and WIDTH=32 against plain-arithmetic expectations.
module tb_serial_subtractor;

  logic        clk;
  logic        reset_n;

  logic        start8;
  logic [7:0]  a8, b8;
  logic        ready8, busy8, done8, borrow8;
  logic [7:0]  diff8;
  logic [1:0]  state8;

  logic        start32;
  logic [31:0] a32, b32;
  logic        ready32, busy32, done32, borrow32;
  logic [31:0] diff32;
  logic [1:0]  state32;

  int vectors = 0;
  int miscompares = 0;

  logic [8:0]  exp_q8[$];
  logic [32:0] exp_q32[$];

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .busy(busy8), .done(done8), .diff(diff8),
    .borrow(borrow8), .fsm_state(state8)
  );

  serial_subtractor #(.WIDTH(32)) u32 (
    .clk(clk), .reset_n(reset_n), .start(start32), .a(a32), .b(b32),
    .ready(ready32), .busy(busy32), .done(done32), .diff(diff32),
    .borrow(borrow32), .fsm_state(state32)
  );

  // clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One 8-bit operation; with disturb set, start is pulsed and the operands
  // are scrambled on RUN cycles 3 and 5.
  task automatic run_op8(input logic [7:0] av, input logic [7:0] bv, input bit disturb);
    logic [8:0] e;
    int k;
    int nbusy;
    @(negedge clk);
    check("ready_before_start8", ready8, 1);
    start8 = 1'b1; a8 = av; b8 = bv;
    exp_q8.push_back({(av < bv) ? 1'b1 : 1'b0, 8'(av - bv)});
    @(negedge clk);
    start8 = 1'b0;
    k = 1;
    nbusy = 0;
    while (!done8 && k <= 12) begin
      if (busy8) nbusy++;
      if (disturb && (k == 3 || k == 5)) begin
        start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
      end else begin
        start8 = 1'b0;
      end
      @(negedge clk);
      k++;
    end
    start8 = 1'b0;
    e = exp_q8.pop_front();
    check("done8_seen", done8, 1);
    check("latency8", k, 9);
    check("busy_cycles8", nbusy, 8);
    check("diff8", diff8, e[7:0]);
    check("borrow8", borrow8, e[8]);
    check("ready_on_done8", ready8, 1);
    @(negedge clk);
    check("done8_width", done8, 0);
    check("diff8_held", diff8, e[7:0]);
  endtask

  task automatic run_op32(input logic [31:0] av, input logic [31:0] bv);
    logic [32:0] e;
    int k;
    @(negedge clk);
    start32 = 1'b1; a32 = av; b32 = bv;
    exp_q32.push_back({(av < bv) ? 1'b1 : 1'b0, 32'(av - bv)});
    @(negedge clk);
    start32 = 1'b0;
    k = 1;
    while (!done32 && k <= 40) begin
      @(negedge clk);
      k++;
    end
    e = exp_q32.pop_front();
    check("done32_seen", done32, 1);
    check("latency32", k, 33);
    check("diff32", diff32, e[31:0]);
    check("borrow32", borrow32, e[32]);
    @(negedge clk);
    check("done32_width", done32, 0);
  endtask

  initial begin
    int first_done;
    int second_done;
    int ready_bad;
    int spurious;
    int k;

    reset_n = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0;
    start32 = 1'b0; a32 = '0; b32 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready8", ready8, 1);
    check("rst_busy8", busy8, 0);
    check("rst_done8", done8, 0);
    check("rst_diff8", diff8, 0);
    check("rst_borrow8", borrow8, 0);
    check("rst_ready32", ready32, 1);
    check("rst_diff32", diff32, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // directed operand pairs
    run_op8(8'h35, 8'h12, 1'b0);
    run_op8(8'h00, 8'h01, 1'b0);
    run_op8(8'hFF, 8'hFF, 1'b0);
    run_op8(8'h80, 8'h7F, 1'b0);
    run_op8(8'h40, 8'h01, 1'b1);

    // back-to-back with start held high
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
    first_done = -1; second_done = -1; ready_bad = 0; k = 0;
    for (int c = 0; c < 30 && second_done < 0; c++) begin
      @(negedge clk);
      k++;
      if (done8) begin
        if (first_done < 0) begin
          first_done = k;
          check("b2b_diff1", diff8, 8'hF0);
          check("b2b_borrow1", borrow8, 1);
          check("b2b_ready_done1", ready8, 1);
          a8 = 8'h05; b8 = 8'h03;
        end else begin
          second_done = k;
          check("b2b_diff2", diff8, 8'h02);
          check("b2b_borrow2", borrow8, 0);
          start8 = 1'b0;
        end
      end else if (ready8) begin
        ready_bad++;
      end
    end
    start8 = 1'b0;
    check("b2b_first_latency", first_done, 9);
    check("b2b_spacing", second_done - first_done, 9);
    check("b2b_ready_in_run", ready_bad, 0);
    @(negedge clk);
    check("b2b_idle_ready", ready8, 1);
    check("b2b_idle_done", done8, 0);

    // asynchronous reset in the middle of RUN
    @(negedge clk);
    start8 = 1'b1; a8 = 8'h35; b8 = 8'h12;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", busy8, 1);
    #2 reset_n = 1'b0;
    #1;
    check("abort_ready", ready8, 1);
    check("abort_busy", busy8, 0);
    check("abort_done", done8, 0);
    check("abort_diff", diff8, 0);
    check("abort_borrow", borrow8, 0);
    @(negedge clk);
    reset_n = 1'b1;
    spurious = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8) spurious++;
    end
    check("abort_no_done", spurious, 0);
    run_op8(8'h09, 8'h04, 1'b0);

    // random pairs at both widths
    for (int i = 0; i < 1000; i++) run_op8(8'($urandom), 8'($urandom), 1'b0);
    run_op32(32'h0, 32'h1);
    run_op32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op32(32'h8000_0000, 32'h7FFF_FFFF);
    for (int i = 0; i < 1000; i++) run_op32($urandom, $urandom);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
